// File: rtl/pulse_table_loader.sv
// pulse_table_loader: parses a valid/ready byte stream into a shadow pulse table.
// The shadow is copied to the active outputs in one edge, either at an
// outer-frame boundary or immediately on a forced commit.
//
// state         | meaning
// S_IDLE        | waiting for a command byte
// S_GET_IDX     | edge write: waiting for the slot index byte
// S_GET_PAY     | collecting little-endian payload bytes into the staging register
// S_WAIT_COMMIT | commit armed, stream stalled until the next boundary pulse
module pulse_table_loader #(
    parameter  int COUNT_BITS = 32,
    parameter  int CH_LOG2    = 3,
    parameter  int ED_MAX     = 255,
    localparam int ED_BITS    = 2*COUNT_BITS + CH_LOG2 + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    input  logic                      i_boundary,
    output logic [31:0]               o_period,
    output logic [31:0]               o_outer_period,
    output logic [7:0]                o_state0,
    output logic [ED_BITS*ED_MAX-1:0] o_eds,
    output logic                      o_logic_reset,
    output logic                      o_commit_pending,
    output logic                      o_err
);
    localparam int EB = (ED_BITS + 7) / 8;
    // Staging must also hold the 4-byte period words when edge words are short.
    localparam int SB = (EB > 4) ? EB : 4;
    localparam int CW = $clog2(SB + 1);
    localparam int IW = (ED_MAX > 1) ? $clog2(ED_MAX) : 1;

    localparam logic [7:0] CMD_EDGE    = 8'h01;
    localparam logic [7:0] CMD_PERIOD  = 8'h02;
    localparam logic [7:0] CMD_OUTER   = 8'h03;
    localparam logic [7:0] CMD_STATE0  = 8'h04;
    localparam logic [7:0] CMD_COMMIT  = 8'h05;
    localparam logic [7:0] CMD_FORCE   = 8'h06;
    localparam logic [7:0] CMD_CLR_ERR = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_IDX,
        S_GET_PAY,
        S_WAIT_COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_cmd;
    logic [7:0]          r_idx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_last;
    logic [SB*8-1:0]     r_stage;
    logic [SB*8-1:0]     w_stage;
    logic                r_rx_ready;
    logic                r_logic_reset;
    logic                r_err;
    logic [31:0]         r_sh_period;
    logic [31:0]         r_sh_outer;
    logic [7:0]          r_sh_state0;
    logic [ED_BITS-1:0]  r_sh_eds [ED_MAX];
    logic [31:0]         r_period;
    logic [31:0]         r_outer;
    logic [7:0]          r_state0;
    logic [ED_BITS-1:0]  r_act_eds [ED_MAX];
    logic                w_accept;
    logic                w_commit;
    logic                w_idx_ok;

    assign w_accept = i_rx_valid & r_rx_ready;
    assign w_idx_ok = ({24'd0, r_idx} < 32'(ED_MAX));
    // A boundary only counts once WAIT_COMMIT is already the registered state,
    // so a boundary coinciding with the 0x05 byte is naturally ignored.
    assign w_commit = ((r_state == S_WAIT_COMMIT) && i_boundary) ||
                      ((r_state == S_IDLE) && w_accept && (i_rx_data == CMD_FORCE));

    // Staging view with the incoming byte merged at the current byte position.
    always_comb begin
        w_stage = r_stage;
        for (int k = 0; k < SB; k++) begin
            if (r_cnt == CW'(k)) begin
                w_stage[k*8 +: 8] = i_rx_data;
            end
        end
    end

    // Next-state decode of the command parser.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_rx_data)
                        CMD_EDGE:                          w_state_next = S_GET_IDX;
                        CMD_PERIOD, CMD_OUTER, CMD_STATE0: w_state_next = S_GET_PAY;
                        CMD_COMMIT:                        w_state_next = S_WAIT_COMMIT;
                        default:                           w_state_next = S_IDLE;
                    endcase
                end
            end
            S_GET_IDX:     if (w_accept) w_state_next = S_GET_PAY;
            S_GET_PAY:     if (w_accept && (r_cnt == r_last)) w_state_next = S_IDLE;
            S_WAIT_COMMIT: if (i_boundary) w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // State register; rx_ready is registered from the next state so it stays low in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rx_ready <= (w_state_next != S_WAIT_COMMIT);
        end
    end

    // Command capture, payload staging, shadow writes and the sticky error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
            r_stage     <= '0;
            r_err       <= 1'b0;
            r_sh_period <= '0;
            r_sh_outer  <= '0;
            r_sh_state0 <= '0;
            for (int i = 0; i < ED_MAX; i++) r_sh_eds[i] <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    r_cmd <= i_rx_data;
                    r_cnt <= '0;
                    case (i_rx_data)
                        CMD_EDGE:              r_last <= CW'(EB - 1);
                        CMD_PERIOD, CMD_OUTER: r_last <= CW'(3);
                        CMD_STATE0:            r_last <= '0;
                        CMD_CLR_ERR:           r_err  <= 1'b0;
                        CMD_COMMIT, CMD_FORCE: ;
                        default:               r_err  <= 1'b1;
                    endcase
                end
                S_GET_IDX: r_idx <= i_rx_data;
                S_GET_PAY: begin
                    r_stage <= w_stage;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == r_last) begin
                        case (r_cmd)
                            CMD_EDGE: begin
                                if (w_idx_ok) r_sh_eds[r_idx[IW-1:0]] <= w_stage[ED_BITS-1:0];
                                else          r_err <= 1'b1;
                            end
                            CMD_PERIOD: r_sh_period <= w_stage[31:0];
                            CMD_OUTER:  r_sh_outer  <= w_stage[31:0];
                            CMD_STATE0: r_sh_state0 <= w_stage[7:0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Commit: copy the whole shadow to the active outputs and pulse logic_reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_logic_reset <= 1'b1;
            r_period      <= '0;
            r_outer       <= '0;
            r_state0      <= '0;
            for (int i = 0; i < ED_MAX; i++) r_act_eds[i] <= '0;
        end else begin
            r_logic_reset <= w_commit;
            if (w_commit) begin
                r_period  <= r_sh_period;
                r_outer   <= r_sh_outer;
                r_state0  <= r_sh_state0;
                r_act_eds <= r_sh_eds;
            end
        end
    end

    for (genvar g = 0; g < ED_MAX; g++) begin : g_eds
        assign o_eds[g*ED_BITS +: ED_BITS] = r_act_eds[g];
    end

    assign o_rx_ready       = r_rx_ready;
    assign o_period         = r_period;
    assign o_outer_period   = r_outer;
    assign o_state0         = r_state0;
    assign o_logic_reset    = r_logic_reset;
    assign o_commit_pending = (r_state == S_WAIT_COMMIT);
    assign o_err            = r_err;

endmodule
